// File: rtl/hazard_ctrl_sb.sv
// Hazard control with forwarding, load-use stall, branch flush and a long-op scoreboard.
// Latency: forwarding and stall/flush are combinational; the scoreboard updates each edge.
// Optional feature macro HAZ_PERF_CNT_EN adds saturating stall/flush event counters.
module hazard_ctrl_sb #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SB     = 4,
  parameter int LAT_W      = 4,
  localparam int CNT_W     = $clog2(NUM_SB + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  long_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  reg_write_e,
  input  logic                  result_src_e,
  input  logic                  pc_src_e,
  input  logic                  long_issue_e,
  input  logic [LAT_W-1:0]      long_lat_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  long_wb_valid,
  output logic [REG_ADDR_W-1:0] long_wb_rd,
  output logic [CNT_W-1:0]      sb_count
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [LAT_W-1:0]      cnt;
  } sb_entry_t;

  sb_entry_t             sb_q [NUM_SB];
  sb_entry_t             sb_d [NUM_SB];
  logic [CNT_W-1:0]      sb_count_q, sb_count_d;
  logic                  ret_found, alloc_found;
  logic [REG_ADDR_W-1:0] ret_rd;
  logic                  lw_stall, sb_stall, cap_stall, stall;
  logic [CNT_W:0]        occ;

  // Operand forwarding: M stage beats W stage; all forced to regfile in reset.
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (rst) begin
      if (reg_write_m && rd_m != '0 && rd_m == rs1_e)      forward_a_e = 2'b10;
      else if (reg_write_w && rd_w != '0 && rd_w == rs1_e) forward_a_e = 2'b01;
      if (reg_write_m && rd_m != '0 && rd_m == rs2_e)      forward_b_e = 2'b10;
      else if (reg_write_w && rd_w != '0 && rd_w == rs2_e) forward_b_e = 2'b01;
    end
  end

  // Stall terms: load-use, RAW/WAW against pending long ops, scoreboard capacity.
  always_comb begin
    lw_stall = result_src_e && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
    // An op issuing this cycle is not in the table yet, so check it directly.
    sb_stall = long_issue_e && rd_e != '0 &&
               (rd_e == rs1_d || rd_e == rs2_d || rd_e == rd_d);
    for (int i = 0; i < NUM_SB; i++) begin
      if (sb_q[i].valid && sb_q[i].rd != '0 &&
          (sb_q[i].rd == rs1_d || sb_q[i].rd == rs2_d || sb_q[i].rd == rd_d))
        sb_stall = 1'b1;
    end
    occ       = {1'b0, sb_count_q} + {{CNT_W{1'b0}}, long_issue_e};
    cap_stall = long_d && (occ >= (CNT_W+1)'(NUM_SB));
    stall     = lw_stall | sb_stall | cap_stall;
  end

  // Pipeline control: a taken branch overrides stall since decode holds a wrong-path instr.
  always_comb begin
    stall_f = rst && stall && !pc_src_e;
    stall_d = rst && stall && !pc_src_e;
    flush_d = rst && pc_src_e;
    flush_e = rst && (stall || pc_src_e);
  end

  // Scoreboard next state: countdown, single lowest-index retire, lowest free-slot allocate.
  always_comb begin
    sb_d        = sb_q;
    ret_found   = 1'b0;
    ret_rd      = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < NUM_SB; i++) begin
      if (!ret_found && sb_q[i].valid && sb_q[i].cnt == LAT_W'(1)) begin
        ret_found = 1'b1;
        ret_rd    = sb_q[i].rd;
        sb_d[i]   = '0;
      end else if (sb_q[i].valid && sb_q[i].cnt > LAT_W'(1)) begin
        sb_d[i].cnt = sb_q[i].cnt - LAT_W'(1);
      end
    end
    // Allocation looks at start-of-cycle validity, so a slot retiring now is not reused.
    for (int i = 0; i < NUM_SB; i++) begin
      if (long_issue_e && !alloc_found && !sb_q[i].valid) begin
        alloc_found   = 1'b1;
        sb_d[i].valid = 1'b1;
        sb_d[i].rd    = rd_e;
        sb_d[i].cnt   = (long_lat_e == '0) ? LAT_W'(1) : long_lat_e;
      end
    end
    sb_count_d = sb_count_q + CNT_W'(alloc_found) - CNT_W'(ret_found);
  end

  // Writeback announce for the retiring entry.
  always_comb begin
    long_wb_valid = rst && ret_found;
    long_wb_rd    = rst ? ret_rd : '0;
    sb_count      = sb_count_q;
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SB; i++) sb_q[i] <= '0;
      sb_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SB; i++) sb_q[i] <= sb_d[i];
      sb_count_q <= sb_count_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Saturating event counters for decode stalls and execute flushes.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_d && perf_stall_q != 32'hFFFF_FFFF) perf_stall_d = perf_stall_q + 32'd1;
    if (flush_e && perf_flush_q != 32'hFFFF_FFFF) perf_flush_d = perf_flush_q + 32'd1;
    perf_stall_cnt = perf_stall_q;
    perf_flush_cnt = perf_flush_q;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Directed bench for hazard_ctrl_sb with default parameters (NUM_SB=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
module tb_hazard_ctrl_sb;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       long_d, reg_write_e, result_src_e, pc_src_e, long_issue_e;
  logic       reg_write_m, reg_write_w;
  logic [3:0] long_lat_e;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, flush_d, flush_e, long_wb_valid;
  logic [4:0] long_wb_rd;
  logic [2:0] sb_count;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl_sb dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .long_d(long_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .reg_write_e(reg_write_e), .result_src_e(result_src_e), .pc_src_e(pc_src_e),
    .long_issue_e(long_issue_e), .long_lat_e(long_lat_e),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .long_wb_valid(long_wb_valid), .long_wb_rd(long_wb_rd), .sb_count(sb_count)
`ifdef HAZ_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic idle_inputs();
    rs1_d = 0; rs2_d = 0; rd_d = 0; long_d = 0;
    rs1_e = 0; rs2_e = 0; rd_e = 0; reg_write_e = 0; result_src_e = 0;
    pc_src_e = 0; long_issue_e = 0; long_lat_e = 0;
    rd_m = 0; rd_w = 0; reg_write_m = 0; reg_write_w = 0;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rs1_e = 5; rd_m = 5; reg_write_m = 1; pc_src_e = 1;
    result_src_e = 1; rd_e = 7; rs1_d = 7;
    #3;
    n_vec++;
    if (forward_a_e !== 2'b00) begin n_err++; $display("FAIL reset_fwd_a got=%b exp=00", forward_a_e); end
    n_vec++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl got=%b exp=0000", {stall_f, stall_d, flush_d, flush_e});
    end
    n_vec++;
    if (sb_count !== 3'd0 || long_wb_valid !== 1'b0 || long_wb_rd !== 5'd0) begin
      n_err++; $display("FAIL reset_sb got cnt=%0d wbv=%b wbrd=%0d exp 0/0/0", sb_count, long_wb_valid, long_wb_rd);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_forward();
    cyc();
    idle_inputs();
    rs1_e = 5; rd_m = 5; rd_w = 5; reg_write_m = 1; reg_write_w = 1;
    #2;
    n_vec++;
    if (forward_a_e !== 2'b10) begin n_err++; $display("FAIL fwd_m_prio got=%b exp=10", forward_a_e); end
    reg_write_m = 0;
    #1;
    n_vec++;
    if (forward_a_e !== 2'b01) begin n_err++; $display("FAIL fwd_w got=%b exp=01", forward_a_e); end
    rd_m = 0; rd_w = 0; reg_write_m = 1;
    #1;
    n_vec++;
    if (forward_a_e !== 2'b00) begin n_err++; $display("FAIL fwd_none got=%b exp=00", forward_a_e); end
    // Port B: W only match, M writes a different register.
    rs1_e = 0; rs2_e = 3; rd_m = 4; rd_w = 3; reg_write_m = 1; reg_write_w = 1;
    #1;
    n_vec++;
    if (forward_b_e !== 2'b01 || forward_a_e !== 2'b00) begin
      n_err++; $display("FAIL fwd_b_w got a=%b b=%b exp a=00 b=01", forward_a_e, forward_b_e);
    end
    // x0 never forwards even when both sources name it.
    rs1_e = 0; rs2_e = 0; rd_m = 0; rd_w = 0;
    #1;
    n_vec++;
    if ({forward_a_e, forward_b_e} !== 4'b0000) begin
      n_err++; $display("FAIL fwd_x0 got=%b exp=0000", {forward_a_e, forward_b_e});
    end
  endtask

  task automatic test_load_use();
    cyc();
    idle_inputs();
    result_src_e = 1; reg_write_e = 1; rd_e = 7; rs2_d = 7;
    #2;
    n_vec++;
    if ({stall_f, stall_d, flush_e, flush_d} !== 4'b1110) begin
      n_err++; $display("FAIL load_use got sf,sd,fe,fd=%b exp=1110", {stall_f, stall_d, flush_e, flush_d});
    end
    // Next cycle E holds the bubble.
    cyc();
    idle_inputs();
    rs2_d = 7;
    #2;
    n_vec++;
    if ({stall_f, stall_d, flush_e, flush_d} !== 4'b0000) begin
      n_err++; $display("FAIL load_use_release got=%b exp=0000", {stall_f, stall_d, flush_e, flush_d});
    end
    // Load into x0 never stalls.
    result_src_e = 1; rd_e = 0; rs1_d = 0;
    #1;
    n_vec++;
    if (stall_d !== 1'b0) begin n_err++; $display("FAIL load_x0 got=%b exp=0", stall_d); end
  endtask

  task automatic test_branch();
    cyc();
    idle_inputs();
    result_src_e = 1; reg_write_e = 1; rd_e = 7; rs2_d = 7; pc_src_e = 1;
    #2;
    n_vec++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0011) begin
      n_err++; $display("FAIL branch_stall got sf,sd,fd,fe=%b exp=0011", {stall_f, stall_d, flush_d, flush_e});
    end
  endtask

  task automatic test_latency();
    cyc();
    idle_inputs();
    long_issue_e = 1; rd_e = 9; long_lat_e = 3; rs1_d = 9;
    #2;
    n_vec++;
    if (stall_d !== 1'b1) begin n_err++; $display("FAIL lat_issue_stall got=%b exp=1", stall_d); end
    cyc();               // edge 0: cnt=3
    long_issue_e = 0; rd_e = 0; long_lat_e = 0;
    #2;
    n_vec++;
    if (stall_d !== 1'b1 || long_wb_valid !== 1'b0 || sb_count !== 3'd1) begin
      n_err++; $display("FAIL lat_e0 got sd=%b wbv=%b cnt=%0d exp 1/0/1", stall_d, long_wb_valid, sb_count);
    end
    cyc();               // edge 1: cnt=2
    #2;
    n_vec++;
    if (stall_d !== 1'b1 || long_wb_valid !== 1'b0) begin
      n_err++; $display("FAIL lat_e1 got sd=%b wbv=%b exp 1/0", stall_d, long_wb_valid);
    end
    cyc();               // edge 2: cnt=1, writeback this cycle
    #2;
    n_vec++;
    if (long_wb_valid !== 1'b1 || long_wb_rd !== 5'd9 || stall_d !== 1'b1) begin
      n_err++; $display("FAIL lat_e2 got wbv=%b rd=%0d sd=%b exp 1/9/1", long_wb_valid, long_wb_rd, stall_d);
    end
    cyc();               // edge 3: entry cleared
    #2;
    n_vec++;
    if (long_wb_valid !== 1'b0 || stall_d !== 1'b0 || sb_count !== 3'd0) begin
      n_err++; $display("FAIL lat_e3 got wbv=%b sd=%b cnt=%0d exp 0/0/0", long_wb_valid, stall_d, sb_count);
    end
    // Latency 0 behaves as 1.
    idle_inputs();
    long_issue_e = 1; rd_e = 4; long_lat_e = 0;
    cyc();
    idle_inputs();
    #2;
    n_vec++;
    if (long_wb_valid !== 1'b1 || long_wb_rd !== 5'd4 || sb_count !== 3'd1) begin
      n_err++; $display("FAIL lat0 got wbv=%b rd=%0d cnt=%0d exp 1/4/1", long_wb_valid, long_wb_rd, sb_count);
    end
    // rd=0 long op still occupies a slot and pulses writeback, but never stalls.
    long_issue_e = 1; rd_e = 0; long_lat_e = 1;
    cyc();
    idle_inputs();
    #2;
    n_vec++;
    if (long_wb_valid !== 1'b1 || long_wb_rd !== 5'd0 || sb_count !== 3'd1 || stall_d !== 1'b0) begin
      n_err++; $display("FAIL rd0_op got wbv=%b rd=%0d cnt=%0d sd=%b exp 1/0/1/0", long_wb_valid, long_wb_rd, sb_count, stall_d);
    end
    cyc();
    #2;
    n_vec++;
    if (long_wb_valid !== 1'b0 || sb_count !== 3'd0) begin
      n_err++; $display("FAIL rd0_clear got wbv=%b cnt=%0d exp 0/0", long_wb_valid, sb_count);
    end
  endtask

  task automatic test_capacity();
    logic [3:0] lats [4];
    logic [4:0] rds  [4];
    lats = '{4'd5, 4'd4, 4'd3, 4'd2};
    rds  = '{5'd10, 5'd11, 5'd12, 5'd13};
    for (int i = 0; i < 4; i++) begin
      cyc();
      idle_inputs();
      long_issue_e = 1; rd_e = rds[i]; long_lat_e = lats[i];
      if (i == 3) long_d = 1;
      #2;
      n_vec++;
      if (sb_count !== 3'(i)) begin n_err++; $display("FAIL cap_fill%0d got=%0d exp=%0d", i, sb_count, i); end
    end
    // With 3 valid and one issuing, a new long op must wait.
    n_vec++;
    if (stall_d !== 1'b1) begin n_err++; $display("FAIL cap_issue_stall got=%b exp=1", stall_d); end
    cyc();
    idle_inputs();
    long_d = 1;
    #2;
    n_vec++;
    if (sb_count !== 3'd4 || stall_d !== 1'b1 || long_wb_valid !== 1'b0) begin
      n_err++; $display("FAIL cap_full got cnt=%0d sd=%b wbv=%b exp 4/1/0", sb_count, stall_d, long_wb_valid);
    end
    cyc();
    #2;
    n_vec++;
    if (long_wb_valid !== 1'b1 || long_wb_rd !== 5'd10 || stall_d !== 1'b1) begin
      n_err++; $display("FAIL cap_wb0 got wbv=%b rd=%0d sd=%b exp 1/10/1", long_wb_valid, long_wb_rd, stall_d);
    end
    for (int i = 1; i < 4; i++) begin
      cyc();
      #2;
      n_vec++;
      if (long_wb_valid !== 1'b1 || long_wb_rd !== rds[i] || sb_count !== 3'(4 - i) || stall_d !== 1'b0) begin
        n_err++; $display("FAIL cap_wb%0d got wbv=%b rd=%0d cnt=%0d sd=%b exp 1/%0d/%0d/0",
                          i, long_wb_valid, long_wb_rd, sb_count, stall_d, rds[i], 4 - i);
      end
    end
    cyc();
    #2;
    n_vec++;
    if (long_wb_valid !== 1'b0 || sb_count !== 3'd0) begin
      n_err++; $display("FAIL cap_drain got wbv=%b cnt=%0d exp 0/0", long_wb_valid, sb_count);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      idle_inputs();
      long_issue_e = 1; rd_e = 5'(i + 1); long_lat_e = 8;
    end
    cyc();
    idle_inputs();
    rs1_d = 1; rs1_e = 6; rd_m = 6; reg_write_m = 1;
    #1;
    n_vec++;
    if (sb_count !== 3'd3 || stall_d !== 1'b1) begin
      n_err++; $display("FAIL areset_pre got cnt=%0d sd=%b exp 3/1", sb_count, stall_d);
    end
    rst = 1'b0;          // mid-cycle, no clock edge
    #1;
    n_vec++;
    if (sb_count !== 3'd0 || {stall_f, stall_d, flush_d, flush_e} !== 4'b0000 ||
        forward_a_e !== 2'b00 || long_wb_valid !== 1'b0) begin
      n_err++; $display("FAIL areset got cnt=%0d ctrl=%b fa=%b wbv=%b exp 0/0000/00/0",
                        sb_count, {stall_f, stall_d, flush_d, flush_e}, forward_a_e, long_wb_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    cyc();
    #2;
    n_vec++;
    if (sb_count !== 3'd0 || stall_d !== 1'b0 || forward_a_e !== 2'b10) begin
      n_err++; $display("FAIL areset_after got cnt=%0d sd=%b fa=%b exp 0/0/10", sb_count, stall_d, forward_a_e);
    end
    idle_inputs();
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf();
    cyc();
    idle_inputs();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    result_src_e = 1; rd_e = 7; rs1_d = 7;
    for (int i = 0; i < 10; i++) cyc();
    idle_inputs();
    #2;
    n_vec++;
    if (perf_stall_cnt !== 32'd10 || perf_flush_cnt !== 32'd10) begin
      n_err++; $display("FAIL perf_count got s=%0d f=%0d exp 10/10", perf_stall_cnt, perf_flush_cnt);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      n_err++; $display("FAIL perf_reset got s=%0d f=%0d exp 0/0", perf_stall_cnt, perf_flush_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_latency();
    test_capacity();
    test_async_reset();
`ifdef HAZ_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
